multicycle_core: RTL and testbench

- Parametrised multi-cycle 16-bit-instruction processor core: FSM controller, 16-entry register file, ALU and program counter in one block.
- Successor to the fixed 8-bit controller/datapath set. Adds configurable data/address width, wait-state handshakes to external instruction and data memories, logic ops, unconditional jump, HALT, illegal-opcode trap, flags and a retired-instruction counter.
- Memories are external; the core is the only master on both.

---
 rtl/multicycle_core_pkg.sv | 45 ++++
 rtl/mc_regfile.sv | 34 +++
 rtl/multicycle_core.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_core_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states, field positions.
package multicycle_core_pkg;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_LDI   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JZ    = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_XOR   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;

    // Instruction field positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RA_HI  = 7;
    localparam int RA_LO  = 4;
    localparam int RB_HI  = 3;
    localparam int RB_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    // Opcodes 0..9 execute; HALT is handled separately; A..E trap.
    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_JMP);
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 16-entry register file: three combinational read ports, one synchronous write port.
module mc_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr_a,
    input  logic [3:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_d
);
    import multicycle_core_pkg::*;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Synchronous clear on reset, otherwise single-port write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    // rd port doubles as the JZ test operand and STORE data
    assign rdata_a = regs_q[raddr_a[REG_AW-1:0]];
    assign rdata_b = regs_q[raddr_b[REG_AW-1:0]];
    assign rdata_d = regs_q[waddr[REG_AW-1:0]];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-instruction core: FSM, regfile, ALU, pc, flags and retire counter.
module multicycle_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
);
    import multicycle_core_pkg::*;

    state_t            state_q;
    logic [15:0]       ir_q;
    logic [ADDR_W-1:0] pc_q;
    logic              zero_q, carry_q, halted_q, illegal_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              imem_req_q, dmem_req_q, dmem_we_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [DATA_W-1:0] dmem_wdata_q;

    logic [3:0]        op, rd, ra, rb;
    logic [DATA_W-1:0] imm_data;
    logic [ADDR_W-1:0] imm_addr;
    logic [DATA_W-1:0] ra_v, rb_v, rd_v;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   sum_ext;
    logic              is_alu, is_mem;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    assign op       = ir_q[OP_HI:OP_LO];
    assign rd       = ir_q[RD_HI:RD_LO];
    assign ra       = ir_q[RA_HI:RA_LO];
    assign rb       = ir_q[RB_HI:RB_LO];
    assign imm_data = DATA_W'(ir_q[IMM_HI:IMM_LO]);
    assign imm_addr = ir_q[ADDR_W-1:0];

    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                    (op == OP_OR)  || (op == OP_XOR);
    assign is_mem = (op == OP_LOAD) || (op == OP_STORE);

    mc_regfile #(.DATA_W(DATA_W)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (rf_wdata),
        .raddr_a (ra),
        .raddr_b (rb),
        .rdata_a (ra_v),
        .rdata_b (rb_v),
        .rdata_d (rd_v)
    );

    // ALU: result and carry; carry means no-borrow for SUB, cleared by logic ops
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum_ext = '0;
        case (op)
            OP_ADD: begin
                sum_ext = {1'b0, ra_v} + {1'b0, rb_v};
                alu_res = sum_ext[DATA_W-1:0];
                alu_c   = sum_ext[DATA_W];
            end
            OP_SUB: begin
                alu_res = ra_v - rb_v;
                alu_c   = (ra_v >= rb_v);
            end
            OP_AND:  alu_res = ra_v & rb_v;
            OP_OR:   alu_res = ra_v | rb_v;
            OP_XOR:  alu_res = ra_v ^ rb_v;
            default: ;
        endcase
    end

    // Register write: ALU/LDI at end of EXEC, LOAD on the dmem ready edge
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_res;
        if (state_q == S_EXEC && (is_alu || op == OP_LDI)) begin
            rf_we    = 1'b1;
            rf_wdata = (op == OP_LDI) ? imm_data : alu_res;
        end else if (state_q == S_MEM && dmem_ready && !dmem_we_q) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
        end
    end

    // Controller: state, pc, flags, counter and registered memory handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ir_q         <= '0;
            pc_q         <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            cnt_q        <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_q       <= imem_rdata;
                        pc_q       <= pc_q + ADDR_W'(1);
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op == OP_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (!op_legal(op)) begin
                        state_q   <= S_HALT;
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_alu) begin
                        zero_q  <= (alu_res == '0);
                        carry_q <= alu_c;
                    end
                    // Jump target overrides the increment done in FETCH
                    if (op == OP_JMP || (op == OP_JZ && rd_v == '0)) pc_q <= imm_addr;
                    if (is_mem) begin
                        state_q     <= S_MEM;
                        dmem_req_q  <= 1'b1;
                        dmem_we_q   <= (op == OP_STORE);
                        dmem_addr_q <= imm_addr;
                        if (op == OP_STORE) dmem_wdata_q <= rd_v;
                    end else begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                end
                S_HALT:  ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign pc          = pc_q;
    assign zero_flag   = zero_q;
    assign carry_flag  = carry_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench: expected fetch addresses and stores are queued with each program
// and popped as the cores hand-shake with the memory models.
module tb_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, start = 1'b0, start2 = 1'b0;
    int   n_cmp = 0, n_bad = 0;

    // ---- core 1: DATA_W=8, ADDR_W=8, memories with programmable wait states
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
    logic [15:0] imem_rdata, instr_count;
    logic        zero_flag, carry_flag, halted, illegal;
    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    int          imem_wait = 0, dmem_wait = 0, iw_cnt = 0, dw_cnt = 0;

    multicycle_core #(.DATA_W(8), .ADDR_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .pc(pc), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    assign imem_ready = imem_req && (iw_cnt >= imem_wait);
    assign dmem_ready = dmem_req && (dw_cnt >= dmem_wait);
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        iw_cnt <= (reset || !imem_req || imem_ready) ? 0 : iw_cnt + 1;
        dw_cnt <= (reset || !dmem_req || dmem_ready) ? 0 : dw_cnt + 1;
        if (reset) for (int i = 0; i < 256; i++) dmem[i] <= '0;
        else if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    // ---- core 2: DATA_W=16, ADDR_W=4, zero-wait memories
    logic        imem_req2, dmem_req2, dmem_we2, zero_flag2, carry_flag2, halted2, illegal2;
    logic [3:0]  imem_addr2, dmem_addr2, pc2;
    logic [15:0] imem_rdata2, dmem_wdata2, dmem_rdata2, instr_count2;
    logic [15:0] imem2 [16];
    logic [15:0] dmem2 [16];

    multicycle_core #(.DATA_W(16), .ADDR_W(4), .CNT_W(16)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(1'b1), .imem_rdata(imem_rdata2),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
        .dmem_ready(1'b1), .dmem_rdata(dmem_rdata2), .pc(pc2), .zero_flag(zero_flag2),
        .carry_flag(carry_flag2), .halted(halted2), .illegal(illegal2), .instr_count(instr_count2)
    );

    assign imem_rdata2 = imem2[imem_addr2];
    assign dmem_rdata2 = dmem2[dmem_addr2];

    always @(posedge clk) begin
        if (reset) for (int i = 0; i < 16; i++) dmem2[i] <= '0;
        else if (dmem_req2 && dmem_we2) dmem2[dmem_addr2] <= dmem_wdata2;
    end

    // ---- scoreboards
    int          exp_fa_q[$], exp_fa2_q[$];
    logic [31:0] exp_st_q[$], exp_st2_q[$];
    int          stab_err = 0;
    logic        pend_i = 1'b0, pend_d = 1'b0;
    logic [7:0]  last_ia = '0;
    logic [16:0] last_d = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pop expected fetches/stores on completed transfers; track handshake stability
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_ready)
                chk("fetch_addr", imem_addr, exp_fa_q.size() ? exp_fa_q.pop_front() : 'hDEAD);
            if (dmem_req && dmem_ready && dmem_we)
                chk("store", {16'(dmem_addr), 8'h00, dmem_wdata},
                    exp_st_q.size() ? 64'(exp_st_q.pop_front()) : 64'hDEAD_0000);
            if (imem_req2)
                chk("fetch_addr2", imem_addr2, exp_fa2_q.size() ? exp_fa2_q.pop_front() : 'hDEAD);
            if (dmem_req2 && dmem_we2)
                chk("store2", {16'(dmem_addr2), dmem_wdata2},
                    exp_st2_q.size() ? 64'(exp_st2_q.pop_front()) : 64'hDEAD_0000);
            if (pend_i && (!imem_req || imem_addr != last_ia)) stab_err++;
            if (pend_d && (!dmem_req || {dmem_we, dmem_addr, dmem_wdata} != last_d)) stab_err++;
        end
        pend_i  = !reset && imem_req && !imem_ready;
        pend_d  = !reset && dmem_req && !dmem_ready;
        last_ia = imem_addr;
        last_d  = {dmem_we, dmem_addr, dmem_wdata};
    end

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        imem_wait = 0; dmem_wait = 0;
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
        for (int i = 0; i < 16; i++) imem2[i] = 16'hF000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse start, then count cycles after the start edge until halted
    task automatic run(input bit sel, output int cyc);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start2 = 1'b0;
        cyc = 0;
        while (!(sel ? halted2 : halted) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("run_halted", sel ? halted2 : halted, 1'b1);
        chk("fa_left", sel ? exp_fa2_q.size() : exp_fa_q.size(), 0);
        chk("st_left", sel ? exp_st2_q.size() : exp_st_q.size(), 0);
    endtask

    int cyc;

    initial begin
        do_reset();
        chk("rst_outs", {imem_req, dmem_req, dmem_we, dmem_addr, dmem_wdata, pc, zero_flag,
                         carry_flag, halted, illegal, instr_count}, 64'h0);
        chk("rst_outs2", {imem_req2, dmem_req2, pc2, halted2, instr_count2}, 64'h0);

        // 1: LDI r1,5; LDI r2,3; SUB r3,r1,r2; HALT -- zero waits
        imem[0] = 16'h3105; imem[1] = 16'h3203; imem[2] = 16'h4312; imem[3] = 16'hF000;
        exp_fa_q = '{0, 1, 2, 3};
        run(0, cyc);
        chk("t1_cycles", cyc, 11);
        chk("t1_flags", {zero_flag, carry_flag}, 2'b01);
        chk("t1_count", instr_count, 3);
        chk("t1_pc_ill", {pc, illegal}, {8'd4, 1'b0});

        // 2: same program, two fetch wait states
        do_reset();
        imem_wait = 2;
        imem[0] = 16'h3105; imem[1] = 16'h3203; imem[2] = 16'h4312; imem[3] = 16'hF000;
        exp_fa_q = '{0, 1, 2, 3};
        run(0, cyc);
        chk("t2_cycles", cyc, 19);
        chk("t2_flags", {zero_flag, carry_flag}, 2'b01);
        chk("t2_count", instr_count, 3);

        // 3: SUB result, STORE/LOAD round trip, one data wait state
        do_reset();
        dmem_wait = 1;
        imem[0] = 16'h3105; imem[1] = 16'h3203; imem[2] = 16'h4312; imem[3] = 16'h1340;
        imem[4] = 16'h34AA; imem[5] = 16'h1410; imem[6] = 16'h0510; imem[7] = 16'h1511;
        exp_fa_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        exp_st_q = '{32'h0040_0002, 32'h0010_00AA, 32'h0011_00AA};
        run(0, cyc);
        chk("t3_cycles", cyc, 34);
        chk("t3_count", instr_count, 8);
        chk("t3_flags", {zero_flag, carry_flag}, 2'b01);

        // 4: taken JZ, untaken JZ, JMP, OR/XOR flags
        do_reset();
        imem[8'h00] = 16'h3000; imem[8'h01] = 16'h5020;
        imem[8'h20] = 16'h3107; imem[8'h21] = 16'h4210; imem[8'h22] = 16'h5130;
        imem[8'h23] = 16'h9005; imem[8'h05] = 16'h7410; imem[8'h06] = 16'h1450;
        imem[8'h07] = 16'h8311;
        exp_fa_q = '{0, 1, 'h20, 'h21, 'h22, 'h23, 5, 6, 7, 8};
        exp_st_q = '{32'h0050_0007};
        run(0, cyc);
        chk("t4_count", instr_count, 9);
        chk("t4_pc", pc, 9);
        chk("t4_flags", {zero_flag, carry_flag}, 2'b10);

        // 5: illegal opcode at pc=3, later start pulses ignored
        do_reset();
        imem[0] = 16'h3101; imem[1] = 16'h3202; imem[2] = 16'h3303; imem[3] = 16'hB000;
        exp_fa_q = '{0, 1, 2, 3};
        run(0, cyc);
        chk("t5_ill", {halted, illegal}, 2'b11);
        chk("t5_pc", pc, 4);
        chk("t5_count", instr_count, 3);
        repeat (3) begin
            start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
        end
        chk("t5_stay", {halted, illegal, imem_req, pc, instr_count}, {3'b110, 8'd4, 16'd3});

        // 6: 16-bit data / 4-bit address core: ADD overflow and pc wrap
        do_reset();
        imem2[0] = 16'h5602; imem2[1] = 16'hF000; imem2[2] = 16'h3000; imem2[3] = 16'h3201;
        imem2[4] = 16'h4102; imem2[5] = 16'h2312; imem2[6] = 16'h1309; imem2[7] = 16'h110A;
        imem2[8] = 16'h900F; imem2[15] = 16'h3601;
        exp_fa2_q = '{0, 2, 3, 4, 5, 6, 7, 8, 15, 0, 1};
        exp_st2_q = '{32'h0009_0000, 32'h000A_FFFF};
        run(1, cyc);
        chk("t6_flags", {zero_flag2, carry_flag2}, 2'b11);
        chk("t6_count", instr_count2, 10);
        chk("t6_pc", pc2, 2);

        // 7: reset while a store is waiting for dmem_ready
        do_reset();
        dmem_wait = 5;
        imem[0] = 16'h3109; imem[1] = 16'h1110;
        exp_fa_q = '{0, 1};
        start = 1'b1; @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!dmem_req && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t7_in_mem", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, {2'b11, 8'h10, 8'h09});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t7_req_drop", dmem_req, 1'b0);
        chk("t7_rst_outs", {imem_req, dmem_req, dmem_we, dmem_addr, dmem_wdata, pc, zero_flag,
                            carry_flag, halted, illegal, instr_count}, 64'h0);
        reset = 1'b0;
        chk("t7_fa_left", exp_fa_q.size(), 0);

        // 8: regfile cleared by that reset -- r1 stores as zero
        dmem_wait = 0;
        imem[0] = 16'h1120; imem[1] = 16'hF000;
        exp_fa_q = '{0, 1};
        exp_st_q = '{32'h0020_0000};
        run(0, cyc);
        chk("t8_count", instr_count, 1);

        chk("hs_stable", stab_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
